// File: rtl/fp24_div.sv
// fp24 divider: quot = a * (1/b) built from a reciprocal unit and a multiplier.
// The datapath never stalls; a credit counter plus a small output FIFO give
// ready/valid flow control on both sides.
// fp24 layout: sign[23], exp[22:16] (bias 63, exp==0 means zero), mant[15:0] with hidden 1.
//
// Ports (fp24_div):
//   clk, rst        : clock and synchronous active-high reset
//   a, b            : dividend and divisor
//   in_valid        : operand pair valid
//   in_ready        : block can accept an operand pair this cycle
//   quot            : quotient at the FIFO head (zero when empty)
//   div_by_zero     : divide-by-zero flag of the FIFO head
//   out_valid       : quot / div_by_zero are valid
//   out_ready       : consumer takes the head this cycle

// Reciprocal of an fp24 value, DELAY cycles of latency, truncated mantissa.
// Ports: clk, b (operand), inv (1/b).
module fp24_inv #(
    parameter int unsigned DELAY = 2
) (
    input  logic        clk,
    input  logic [23:0] b,
    output logic [23:0] inv
);
    logic [16:0]       den;
    logic [17:0]       q;
    logic signed [8:0] e_c;
    logic [23:0]       inv_c;
    logic [23:0]       pipe [DELAY];

    // q = 2^33 / 1.m scaled, lies in (2^16, 2^17]; q == 2^17 only for m == 0.
    always_comb begin
        den = {1'b1, b[15:0]};
        q   = 18'(34'h2_0000_0000 / {17'd0, den});
        if (q[17]) begin
            e_c = 9'sd126 - $signed({2'b00, b[22:16]});
        end else begin
            e_c = 9'sd125 - $signed({2'b00, b[22:16]});
        end
        inv_c = {b[23], 7'h7F, 16'hFFFF};
        if (b[22:16] == 7'd0) begin
            inv_c = {b[23], 7'h7F, 16'hFFFF};
        end else if (e_c < 9'sd1) begin
            inv_c = {b[23], 23'd0};
        end else begin
            inv_c = {b[23], 7'(e_c), (q[17] ? 16'd0 : 16'(q))};
        end
    end

    // Latency pipe.
    always_ff @(posedge clk) begin
        pipe[0] <= inv_c;
        for (int i = 1; i < int'(DELAY); i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign inv = pipe[DELAY-1];
endmodule

// fp24 multiplier, DELAY cycles of latency, truncated mantissa.
// Ports: clk, x, y (operands), p (product).
module fp24_mul #(
    parameter int unsigned DELAY = 1
) (
    input  logic        clk,
    input  logic [23:0] x,
    input  logic [23:0] y,
    output logic [23:0] p
);
    logic [33:0]       prod;
    logic [17:0]       top18;
    logic signed [9:0] e_c;
    logic              s_c;
    logic [23:0]       p_c;
    logic [23:0]       pipe [DELAY];

    // Significand product lies in [2^32, 2^34); top18[17] flags the upper binade.
    always_comb begin
        s_c   = x[23] ^ y[23];
        prod  = {17'd0, 1'b1, x[15:0]} * {17'd0, 1'b1, y[15:0]};
        top18 = 18'(prod >> 16);
        e_c   = $signed({3'b000, x[22:16]}) + $signed({3'b000, y[22:16]}) - 10'sd63
              + (top18[17] ? 10'sd1 : 10'sd0);
        p_c   = 24'd0;
        if (x[22:16] == 7'd0 || y[22:16] == 7'd0) begin
            p_c = 24'd0;
        end else if (e_c < 10'sd1) begin
            p_c = {s_c, 23'd0};
        end else if (e_c > 10'sd127) begin
            p_c = {s_c, 7'h7F, 16'hFFFF};
        end else begin
            p_c = {s_c, 7'(e_c), (top18[17] ? top18[16:1] : top18[15:0])};
        end
    end

    // Latency pipe.
    always_ff @(posedge clk) begin
        pipe[0] <= p_c;
        for (int i = 1; i < int'(DELAY); i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign p = pipe[DELAY-1];
endmodule

module fp24_div #(
    parameter int unsigned MUL_DELAY  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] quot,
    output logic        div_by_zero,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int unsigned INV_DELAY = 2;
    localparam int unsigned DIV_DELAY = INV_DELAY + MUL_DELAY;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic b_zero;
        logic a_zero;
        logic sign;
    } side_t;

    logic                 accept;
    logic                 pop;
    logic                 retire;
    logic [23:0]          a_pipe [INV_DELAY];
    logic [23:0]          b_inv;
    logic [23:0]          prod;
    logic [DIV_DELAY-1:0] vld_sr;
    side_t                side_pipe [DIV_DELAY];
    side_t                side_in;
    side_t                side_tail;
    logic [24:0]          entry;
    logic [24:0]          mem [FIFO_DEPTH];
    logic [24:0]          head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W:0]       occ;

    // Credits: every accepted pair already owns a FIFO slot, so the FIFO cannot overflow.
    assign occ      = (CNT_W+1)'(inflight) + (CNT_W+1)'(count);
    assign in_ready = !rst && (occ < (CNT_W+1)'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign retire   = vld_sr[DIV_DELAY-1];

    assign side_in.b_zero = (b[22:16] == 7'd0);
    assign side_in.a_zero = (a[22:16] == 7'd0);
    assign side_in.sign   = a[23] ^ b[23];

    fp24_inv #(.DELAY(INV_DELAY)) u_inv (
        .clk (clk),
        .b   (b),
        .inv (b_inv)
    );

    // Dividend alignment pipe, matching the reciprocal latency.
    always_ff @(posedge clk) begin
        a_pipe[0] <= a;
        for (int i = 1; i < int'(INV_DELAY); i++) begin
            a_pipe[i] <= a_pipe[i-1];
        end
    end

    fp24_mul #(.DELAY(MUL_DELAY)) u_mul (
        .clk (clk),
        .x   (a_pipe[INV_DELAY-1]),
        .y   (b_inv),
        .p   (prod)
    );

    // Valid tracking and special-case sideband, both DIV_DELAY deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < int'(DIV_DELAY); i++) begin
                side_pipe[i] <= '0;
            end
        end else begin
            vld_sr       <= {vld_sr[DIV_DELAY-2:0], accept};
            side_pipe[0] <= side_in;
            for (int i = 1; i < int'(DIV_DELAY); i++) begin
                side_pipe[i] <= side_pipe[i-1];
            end
        end
    end

    assign side_tail = side_pipe[DIV_DELAY-1];

    // Retiring entry: special cases override the multiplier product.
    always_comb begin
        entry = {1'b0, prod};
        if (side_tail.b_zero) begin
            entry = {1'b1, side_tail.sign, 7'h7F, 16'hFFFF};
        end else if (side_tail.a_zero) begin
            entry = 25'd0;
        end
    end

    // Inflight counter and FIFO control.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= inflight + CNT_W'(accept) - CNT_W'(retire);
            count    <= count + CNT_W'(retire) - CNT_W'(pop);
            if (retire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (retire) begin
            mem[wr_ptr] <= entry;
        end
    end

    assign head        = mem[rd_ptr];
    assign out_valid   = (count != '0);
    assign quot        = out_valid ? head[23:0] : 24'd0;
    assign div_by_zero = out_valid && head[24];
endmodule

// File: tb/tb_fp24_div.sv
// Scoreboard bench for fp24_div: expected results are queued on accept and
// compared in order when the DUT pops a result.
module tb_fp24_div;
    localparam int unsigned MUL_DELAY  = 1;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DIV_DELAY  = 2 + MUL_DELAY;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] a;
    logic [23:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] quot;
    logic        div_by_zero;
    logic        out_valid;
    logic        out_ready;

    typedef struct packed {
        logic        dbz;
        logic [23:0] q;
    } exp_t;

    exp_t        sb [$];
    int          pop_log [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        last_acc;
    logic        last_ov;
    logic        hold_pending;
    logic [24:0] hold_val;

    always #5 clk = ~clk;

    fp24_div #(.MUL_DELAY(MUL_DELAY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .quot        (quot),
        .div_by_zero (div_by_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic check(input string tag, input longint got, input longint want, input longint tol);
        longint d;
        n_checks++;
        d = (got > want) ? got - want : want - got;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h tol=%0d (cycle %0d)", tag, got, want, tol, cyc);
        end
    endtask

    // Exact quotient truncated to 16 mantissa bits, via long integer division.
    function automatic exp_t ref_div(input logic [23:0] x, input logic [23:0] y);
        exp_t        r;
        logic        s;
        logic [33:0] num;
        logic [33:0] den;
        logic [33:0] q;
        int          e;
        s = x[23] ^ y[23];
        if (y[22:16] == 7'd0) begin
            r.dbz = 1'b1;
            r.q   = {s, 7'h7F, 16'hFFFF};
        end else if (x[22:16] == 7'd0) begin
            r.dbz = 1'b0;
            r.q   = 24'd0;
        end else begin
            num = {1'b1, x[15:0], 17'd0};
            den = {17'd0, 1'b1, y[15:0]};
            q   = num / den;
            e   = int'(x[22:16]) - int'(y[22:16]) + 63;
            r.dbz = 1'b0;
            if (q[17]) begin
                r.q = {s, 7'(e), q[16:1]};
            end else begin
                r.q = {s, 7'(e - 1), q[15:0]};
            end
        end
        return r;
    endfunction

    // Operands kept in an exponent band where neither reciprocal nor quotient leaves range.
    function automatic logic [23:0] rand_operand();
        logic [23:0] v;
        v[23]    = 1'($urandom);
        v[15:0]  = 16'($urandom);
        v[22:16] = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(40, 86));
        return v;
    endfunction

    // One clock: drive inputs, sample just after, update scoreboard, advance to next negedge.
    task automatic cycle(input logic iv, input logic [23:0] ia, input logic [23:0] ib, input logic ordy);
        exp_t e;
        logic special;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        #1;
        last_acc = in_valid && in_ready;
        last_ov  = out_valid;
        if (hold_pending && out_valid) begin
            check("hold", {div_by_zero, quot}, hold_val, 0);
        end
        hold_pending = out_valid && !out_ready;
        hold_val     = {div_by_zero, quot};
        if (out_valid && out_ready) begin
            pop_log.push_back(cyc);
            if (sb.size() == 0) begin
                check("spurious", 1, 0, 0);
            end else begin
                e       = sb.pop_front();
                special = e.dbz || (e.q == 24'd0);
                check("dbz",  div_by_zero, e.dbz, 0);
                check("sign", quot[23], e.q[23], 0);
                check("mag",  quot[22:0], e.q[22:0], special ? 0 : 4);
            end
        end
        if (last_acc) begin
            sb.push_back(ref_div(ia, ib));
        end
        check("occupancy", (sb.size() <= FIFO_DEPTH), 1, 0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            cycle(1'b0, 24'd0, 24'd0, 1'b1);
            n++;
        end
        check("drain", sb.size(), 0, 0);
        repeat (4) cycle(1'b0, 24'd0, 24'd0, 1'b1);
    endtask

    initial begin
        int n;
        int n_acc;
        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = 24'd0;
        b            = 24'd0;
        out_ready    = 1'b0;
        hold_pending = 1'b0;
        last_acc     = 1'b0;
        last_ov      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        #1;
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_quot", quot, 0, 0);
        check("rst_dbz", div_by_zero, 0, 0);
        check("rst_in_ready", in_ready, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1, 0);
        @(negedge clk);

        // Single operation latency: 6.0 / 2.0.
        cycle(1'b1, 24'h418000, 24'h400000, 1'b1);
        check("lat_accept", last_acc, 1, 0);
        n = 0;
        do begin
            cycle(1'b0, 24'd0, 24'd0, 1'b1);
            n++;
        end while (!last_ov && n < 20);
        check("latency", n, DIV_DELAY + 1, 0);
        drain();

        // Back-to-back operations come out on consecutive cycles, in order.
        pop_log.delete();
        cycle(1'b1, 24'hC08000, 24'h400000, 1'b1);
        cycle(1'b1, 24'h3F0000, 24'h410000, 1'b1);
        drain();
        check("b2b_count", pop_log.size(), 2, 0);
        if (pop_log.size() == 2) begin
            check("b2b_gap", pop_log[1] - pop_log[0], 1, 0);
        end

        // Special cases: x/0, 0/0, -x/0, 0/x.
        cycle(1'b1, 24'h408000, 24'h000000, 1'b1);
        cycle(1'b1, 24'h000000, 24'h000000, 1'b1);
        cycle(1'b1, 24'hC08000, 24'h000000, 1'b1);
        cycle(1'b1, 24'h000000, 24'h400000, 1'b1);
        drain();

        // Fill with the consumer stalled, then drain.
        n_acc = 0;
        for (int i = 0; i < 3 * int'(FIFO_DEPTH); i++) begin
            cycle(1'b1, rand_operand(), rand_operand(), 1'b0);
            n_acc += int'(last_acc);
        end
        check("fill_accepts", n_acc, FIFO_DEPTH, 0);
        check("fill_ready", in_ready, 0, 0);
        check("fill_out_valid", out_valid, 1, 0);
        pop_log.delete();
        drain();
        check("fill_drained", pop_log.size(), FIFO_DEPTH, 0);

        // Random traffic against the reference model.
        n_acc = 0;
        n = 0;
        while (n_acc < 10000 && n < 60000) begin
            cycle(($urandom_range(0, 9) < 7), rand_operand(), rand_operand(), ($urandom_range(0, 9) < 7));
            n_acc += int'(last_acc);
            n++;
        end
        check("rand_count", n_acc, 10000, 0);
        drain();

        // Reset with 3 in flight and 2 queued.
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, rand_operand(), rand_operand(), 1'b0);
            n_acc += int'(last_acc);
        end
        check("mid_accepts", n_acc, 5, 0);
        check("mid_queued", out_valid, 1, 0);
        rst = 1'b1;
        cycle(1'b1, 24'h418000, 24'h400000, 1'b0);
        check("mid_rst_ready", last_acc, 0, 0);
        rst = 1'b0;
        sb.delete();
        hold_pending = 1'b0;
        cycle(1'b0, 24'd0, 24'd0, 1'b1);
        check("mid_out_valid", last_ov, 0, 0);
        check("mid_quot", quot, 0, 0);
        check("mid_in_ready", in_ready, 1, 0);
        repeat (20) cycle(1'b0, 24'd0, 24'd0, 1'b1);
        cycle(1'b1, 24'h418000, 24'h400000, 1'b1);
        check("recover_accept", last_acc, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
